// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus cycle engine.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_STB,
        A_HLD,
        D_SET,
        D_STB,
        D_HLD,
        GAP
    } bus_st_t;

    // Bit order: {ad, cs, rd, wr}, all active-low.
    localparam logic [3:0] STROBE_IDLE = 4'b1111;

    localparam int T_PHASE_DEF = 10;
    localparam int T_GAP_DEF   = 4;

endpackage

// File: rtl/rtc_bus_cycle_phase_timer.sv
// Loadable down-counter that measures how long the bus FSM stays in a state.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Bus-cycle engine: turns one request into an address phase plus data phase
// on the RTC chip's multiplexed AD port, then pulses done.
module rtc_bus_cycle
    import rtc_pkg::*;
#(
    parameter int T_PHASE = T_PHASE_DEF,
    parameter int T_GAP   = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rnw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    input  logic [7:0] ADin,
    output logic [7:0] ADout,
    output logic       oe,
    output logic       ad,
    output logic       cs,
    output logic       rd,
    output logic       wr
);

    localparam int TMAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
    localparam int CW   = $clog2(TMAX) + 1;
    localparam logic [CW-1:0] PH_LOAD  = CW'(T_PHASE - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(T_GAP - 1);

    bus_st_t       st, st_nxt;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] tmr_cnt;
    logic          tmr_zero;

    logic          accept;
    logic          rnw_q, rnw_n;
    logic [7:0]    addr_q, addr_n;
    logic [7:0]    wdata_q, wdata_n;

    logic          ad_n, cs_n, rd_n, wr_n, oe_n, busy_n, done_n;
    logic [7:0]    adout_n;

    phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_cnt),
        .zero     (tmr_zero)
    );

    assign accept  = (st == IDLE) && start;
    // Outputs are registered from the next state, so the request fields must
    // be visible in the same cycle they are latched.
    assign rnw_n   = accept ? rnw   : rnw_q;
    assign addr_n  = accept ? addr  : addr_q;
    assign wdata_n = accept ? wdata : wdata_q;

    always_comb begin
        st_nxt   = st;
        tmr_load = 1'b0;
        tmr_val  = PH_LOAD;
        case (st)
            IDLE: begin
                if (start) begin
                    st_nxt   = A_SET;
                    tmr_load = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) st_nxt = IDLE;
            end
            default: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    case (st)
                        A_SET:   st_nxt = A_STB;
                        A_STB:   st_nxt = A_HLD;
                        A_HLD:   st_nxt = D_SET;
                        D_SET:   st_nxt = D_STB;
                        D_STB:   st_nxt = D_HLD;
                        default: begin
                            st_nxt  = GAP;
                            tmr_val = GAP_LOAD;
                        end
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        {ad_n, cs_n, rd_n, wr_n} = STROBE_IDLE;
        oe_n    = 1'b0;
        adout_n = '0;
        busy_n  = (st_nxt != IDLE);
        done_n  = (st == GAP) && (st_nxt == IDLE);
        case (st_nxt)
            A_SET, A_STB, A_HLD: begin
                ad_n    = 1'b0;
                cs_n    = 1'b0;
                oe_n    = 1'b1;
                adout_n = addr_n;
                wr_n    = (st_nxt != A_STB);
            end
            D_SET, D_STB, D_HLD: begin
                cs_n    = 1'b0;
                oe_n    = !rnw_n;
                adout_n = rnw_n ? 8'h00 : wdata_n;
                if (st_nxt == D_STB) begin
                    if (rnw_n) rd_n = 1'b0;
                    else       wr_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rnw_q   <= rnw;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st               <= IDLE;
            {ad, cs, rd, wr} <= STROBE_IDLE;
            oe               <= 1'b0;
            ADout            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            rdata            <= '0;
        end else begin
            st               <= st_nxt;
            {ad, cs, rd, wr} <= {ad_n, cs_n, rd_n, wr_n};
            oe               <= oe_n;
            ADout            <= adout_n;
            busy             <= busy_n;
            done             <= done_n;
            // Sample the chip at the end of the final read-strobe cycle.
            if (st == D_STB && rnw_q && tmr_cnt == '0) rdata <= ADin;
        end
    end

endmodule
